// File: rtl/mem_bus_pkg.sv
// Shared bus definitions for the memory-port arbiter: strobe constants,
// default widths, read-response pipeline entry and lock-state encoding.
package mem_bus_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [3:0] WSTRB_HALF = 4'b0011;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  // One slot of the read-latency pipeline; id names the requester to answer.
  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } resp_entry_t;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above ptr,
// wrapping to index 0; returns one-hot winner, its index and an any flag.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    // First pass covers ptr..N-1, second pass wraps over 0..ptr-1.
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && elig[i] && (i >= 32'(ptr))) begin
        any    = 1'b1;
        win[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && elig[i] && (i < 32'(ptr))) begin
        any    = 1'b1;
        win[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between
// N_REQ requesters, routing read responses back by id. Optional bus lock: ARB_LOCK_EN.
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          req_we_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W/8-1:0] req_wstrb_i,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [N_REQ-1:0]          lock_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  input  logic                      mem_ready_i,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W/8-1:0]       mem_wstrb_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             xfer;
  logic             locked;

  resp_entry_t      pipe_q [RD_LATENCY];

`ifdef ARB_LOCK_EN
  lock_state_e      lock_q, lock_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] owner_mask;
  logic             win_lock;

  assign locked   = (lock_q == LOCK_LOCKED);
  assign win_lock = |(lock_i & win_oh);

  always_comb begin
    owner_mask = '0;
    for (int unsigned n = 0; n < N_REQ; n++) begin
      owner_mask[n] = (owner_q == IDX_W'(n));
    end
  end

  assign elig = locked ? (req_i & owner_mask) : req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= LOCK_UNLOCKED;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end

  // While locked only the owner is eligible, so any transfer is the owner's.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    case (lock_q)
      LOCK_UNLOCKED: begin
        if (xfer && win_lock) begin
          lock_d  = LOCK_LOCKED;
          owner_d = win_idx;
        end
      end
      LOCK_LOCKED: begin
        if (xfer && !win_lock) begin
          lock_d = LOCK_UNLOCKED;
        end
      end
      default: lock_d = LOCK_UNLOCKED;
    endcase
  end
`else
  logic unused_lock;

  assign unused_lock = ^lock_i;
  assign locked      = 1'b0;
  assign elig        = req_i;
`endif

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .elig (elig),
    .ptr  (ptr_q),
    .win  (win_oh),
    .idx  (win_idx),
    .any  (win_any)
  );

  assign xfer     = win_any & mem_ready_i;
  assign gnt_o    = win_oh & {N_REQ{xfer & rst_ni}};
  assign mem_en_o = xfer & rst_ni;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wstrb_o = '0;
    mem_wdata_o = '0;
    for (int unsigned n = 0; n < N_REQ; n++) begin
      if (win_oh[n]) begin
        mem_we_o    = req_we_i[n];
        mem_addr_o  = req_addr_i[n*ADDR_W +: ADDR_W];
        mem_wstrb_o = req_wstrb_i[n*STRB_W +: STRB_W];
        mem_wdata_o = req_wdata_i[n*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer && !locked) begin
      ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < RD_LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q[0].valid <= xfer & ~mem_we_o;
      pipe_q[0].id    <= 3'(win_idx);
      for (int unsigned k = 1; k < RD_LATENCY; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    for (int unsigned n = 0; n < N_REQ; n++) begin
      rvalid_o[n] = rst_ni & pipe_q[RD_LATENCY-1].valid &
                    (pipe_q[RD_LATENCY-1].id == 3'(n));
    end
  end

  assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a behavioural
// memory/arbitration model; lock scenarios run when ARB_LOCK_EN is defined.
module tb_mem_port_arbiter;
  import mem_bus_pkg::*;

  localparam int N   = 2;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_bus, we_bus, lock_bus;
  logic [N*32-1:0] addr_bus, wdata_bus;
  logic [N*4-1:0]  strb_bus;
  logic [N-1:0]    gnt, rvalid;
  logic [31:0]     rdata;
  logic            mem_ready, mem_en, mem_we;
  logic [31:0]     mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_wstrb;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .N_REQ      (N),
    .ADDR_W     (32),
    .DATA_W     (32),
    .RD_LATENCY (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req_bus),
    .req_we_i    (we_bus),
    .req_addr_i  (addr_bus),
    .req_wstrb_i (strb_bus),
    .req_wdata_i (wdata_bus),
    .lock_i      (lock_bus),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .mem_ready_i (mem_ready),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wstrb_o (mem_wstrb),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Requester-side payloads, held by the bench until granted.
  logic        m_req   [N];
  logic        m_we    [N];
  logic        m_lock  [N];
  logic [31:0] m_addr  [N];
  logic [3:0]  m_strb  [N];
  logic [31:0] m_wdata [N];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] mem_m [logic [31:0]];
  int          ptr_m;
  int          owner_m;
  int          cyc;
  int          last_xfer;
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

  function automatic int pick();
    for (int off = 0; off < N; off++) begin
      int i;
      i = (ptr_m + off) % N;
      if (m_req[i] && (owner_m < 0 || owner_m == i)) return i;
    end
    return -1;
  endfunction

  task automatic cycle();
    int          w;
    logic [N-1:0] exp_gnt, exp_rv;
    logic [31:0] exp_rd, tmp;
    for (int n = 0; n < N; n++) begin
      req_bus[n]             = m_req[n];
      we_bus[n]              = m_we[n];
      lock_bus[n]            = m_lock[n];
      addr_bus[n*32 +: 32]   = m_addr[n];
      strb_bus[n*4 +: 4]     = m_strb[n];
      wdata_bus[n*32 +: 32]  = m_wdata[n];
    end
    if (!rst_n) begin
      rq.delete();
      ptr_m   = 0;
      owner_m = -1;
    end
    mem_rdata = $urandom;
    exp_rv    = '0;
    exp_rd    = '0;
    foreach (rq[k]) begin
      if (rq[k].due == cyc) begin
        exp_rv[rq[k].id] = 1'b1;
        exp_rd           = rq[k].data;
        mem_rdata        = rq[k].data;
      end
    end
    #1;
    w       = pick();
    exp_gnt = '0;
    if (rst_n && mem_ready && w >= 0) exp_gnt[w] = 1'b1;
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("mem_en", 64'(mem_en), 64'(exp_gnt != '0));
    check("rvalid", 64'(rvalid), 64'(exp_rv));
    if (exp_rv != '0) check("rdata", 64'(rdata), 64'(exp_rd));
    check("mem_we", 64'(mem_we), (w >= 0) ? 64'(m_we[w]) : 64'd0);
    check("mem_addr", 64'(mem_addr), (w >= 0) ? 64'(m_addr[w]) : 64'd0);
    check("mem_wstrb", 64'(mem_wstrb), (w >= 0) ? 64'(m_strb[w]) : 64'd0);
    check("mem_wdata", 64'(mem_wdata), (w >= 0) ? 64'(m_wdata[w]) : 64'd0);
    @(posedge clk);
    last_xfer = -1;
    if (rst_n && mem_ready && w >= 0) begin
      last_xfer = w;
      if (owner_m >= 0) begin
        if (!m_lock[w]) owner_m = -1;
      end else begin
        ptr_m = (w + 1) % N;
`ifdef ARB_LOCK_EN
        if (m_lock[w]) owner_m = w;
`endif
      end
      if (m_we[w]) begin
        tmp = mem_rd(m_addr[w]);
        for (int b = 0; b < 4; b++)
          if (m_strb[w][b]) tmp[b*8 +: 8] = m_wdata[w][b*8 +: 8];
        mem_m[m_addr[w]] = tmp;
      end else begin
        rq.push_back('{due: cyc + LAT, id: w, data: mem_rd(m_addr[w])});
      end
    end
    for (int k = rq.size() - 1; k >= 0; k--)
      if (rq[k].due <= cyc) rq.delete(k);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic r, input logic we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d, input logic lk);
    m_req[n] = r; m_we[n] = we; m_addr[n] = a; m_strb[n] = s; m_wdata[n] = d; m_lock[n] = lk;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; ptr_m = 0; owner_m = -1; last_xfer = -1;
    rst_n = 1'b0; mem_ready = 1'b1;
    for (int n = 0; n < N; n++) set_req(n, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    // Reset state with a pending request: nothing may be granted.
    set_req(0, 1'b1, 1'b0, 32'h10, WSTRB_WORD, '0, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Reset mid-read: grant, one cycle, then async reset pulse.
    cycle();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cycle();
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h20, WSTRB_WORD, '0, 1'b0);
    set_req(1, 1'b1, 1'b0, 32'h24, WSTRB_WORD, '0, 1'b0);
    cycle();
    rst_n = 1'b1;

    // Contention: both reading, grants alternate starting at 0.
    for (int i = 0; i < 6; i++) cycle();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < LAT + 1; i++) cycle();

    // Read return to requester 1.
    mem_m[32'h100] = 32'hDEADBEEF;
    set_req(1, 1'b1, 1'b0, 32'h100, WSTRB_WORD, '0, 1'b0);
    cycle();
    set_req(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < LAT + 1; i++) cycle();

    // Backpressure: held request waits for mem_ready.
    set_req(0, 1'b1, 1'b0, 32'h100, WSTRB_WORD, '0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    mem_ready = 1'b1;
    cycle();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < LAT + 1; i++) cycle();

    // Byte write, then zero-strobe write, then read back.
    set_req(0, 1'b1, 1'b1, 32'h40, WSTRB_BYTE, 32'h0000_00AA, 1'b0);
    cycle();
    set_req(0, 1'b1, 1'b1, 32'h40, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    cycle();
    set_req(0, 1'b1, 1'b0, 32'h40, WSTRB_WORD, '0, 1'b0);
    cycle();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < LAT + 1; i++) cycle();

`ifdef ARB_LOCK_EN
    // Lock: req 0 holds the bus for 3 grants, releases, then req 1 wins.
    set_req(1, 1'b1, 1'b0, 32'h44, WSTRB_WORD, '0, 1'b0);
    set_req(0, 1'b1, 1'b0, 32'h40, WSTRB_WORD, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    set_req(0, 1'b1, 1'b1, 32'h40, WSTRB_HALF, 32'h1234_5678, 1'b0);
    cycle();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cycle();
    set_req(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < LAT + 1; i++) cycle();
`endif

    // Randomized traffic; payloads only change after their grant.
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < N; n++) begin
        if (!m_req[n] || last_xfer == n)
          set_req(n, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  {26'd0, 4'($urandom_range(0, 15)), 2'b00}, 4'($urandom),
                  $urandom, $urandom_range(0, 3) == 0);
      end
      mem_ready = $urandom_range(0, 4) != 0;
      if (i == 200) rst_n = 1'b0;
      if (i == 201) rst_n = 1'b1;
      cycle();
    end
    for (int n = 0; n < N; n++) set_req(n, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    mem_ready = 1'b1;
    for (int i = 0; i < LAT + 2; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
